lu_vector_driver: RTL and testbench
===================================

Name: lu_vector_driver

Overview:
- Initiator side of the OR/NOR logic-unit interface: the block drives operands and the operation select into a W-bit OR/NOR logic unit, then samples the unit's result.
- It steps exhaustively through every (a, b, sel) combination and compares each result against an internally computed golden value.
- It reports a pass/fail verdict, a mismatch count and the first failing vector.
- Position: sits beside any logic-unit instance as a self-test engine, driven by a start pulse from a controller or bench.

Parameters:
- W, 1, operand width of the logic unit under test; legal range 1..4.
- SETTLE, 1, wait cycles between driving a vector and sampling the result; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous; terminates a sweep in progress.
- lu_a  output  W  operand a driven to the logic unit.
- lu_b  output  W  operand b driven to the logic unit.
- lu_sel  output  1  operation select; 1 = OR, 0 = NOR.
- lu_out  input  W  result returned by the logic unit.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  2W+2  number of mismatching vectors in the last or current sweep.
- first_fail  output  2W+1  vector index {sel,a,b} of the first mismatch; valid when err_count != 0.

Behaviour:
- Vector index vec, N = 2W+1 bits, is packed as {sel, a, b}: lu_sel = vec[2W], lu_a = vec[2W-1:W], lu_b = vec[W-1:0].
- Golden result: sel=1 -> a | b; sel=0 -> ~(a | b); compared bitwise across all W bits.
- Reset (asynchronous, rst=1):
  - state=IDLE; vec=0; lu_a=0, lu_b=0, lu_sel=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail=0.
  - Internal wait counter cleared.
- States:
  - IDLE:
    - start=1 -> vec=0, err_count=0, first_fail=0, pass=0, busy=1 -> WAIT, with the wait counter loaded to SETTLE.
    - Outputs hold their last values while in IDLE.
  - WAIT:
    - Wait counter decrements each cycle; reaching 1 -> CHECK.
    - Total hold is exactly SETTLE cycles with vec stable.
  - CHECK (one cycle):
    - Sample lu_out. On mismatch, err_count++; if this is the first mismatch (err_count was 0), first_fail=vec.
    - If vec == 2^N-1 -> DONE.
    - Otherwise vec++ and -> WAIT, with the wait counter reloaded to SETTLE.
  - DONE (one cycle): done=1, busy=0, pass=(err_count==0, including the final CHECK's update) -> IDLE.
- Latency per vector is SETTLE+1 cycles.
- Full sweep, start to done pulse: 2^N*(SETTLE+1)+1 cycles. For W=1, SETTLE=1 that is 17 cycles.
- start while busy: ignored, no restart.
- abort: valid in WAIT or CHECK.
  - Next state is IDLE; busy=0; done is not pulsed; pass=0.
  - err_count and first_fail keep their partial values.
  - The CHECK sample in the abort cycle is discarded.
- abort in IDLE or DONE: ignored.
- start and abort in the same IDLE cycle: start wins.
- err_count is sized to hold 2^N without overflow; no saturation logic is needed.
- rst asserted mid-sweep: immediate return to reset values; no done pulse.

Decomposition:
- Shared package lu_pkg holds:
  - SEL_OR=1'b1, SEL_NOR=1'b0.
  - State encoding typedef lu_drv_state_t {IDLE, WAIT, CHECK, DONE}.
  - A function lu_golden(a, b, sel), reused by the bench scoreboard.
- One natural sub-module: lu_settle_timer, a loadable down-counter with SETTLE load and an expire flag.
- The vector counter and compare logic stay in the top module.

Test Plan:
- Correct LU model, W=1, SETTLE=1; pulse start -> 8 vectors driven in order 000..111; done pulses on cycle 17 after start; pass=1, err_count=0.
- LU with output stuck at 0, W=1 -> mismatches at vec 0 (NOR 0,0=1), 5, 6, 7; err_count=4, first_fail=3'b000, pass=0.
- LU with sel inverted (OR/NOR swapped), W=2, SETTLE=3 -> all 32 vectors fail; err_count=32, first_fail=0; done after 129 cycles.
- Abort asserted during the WAIT of vec=3, stuck-0 model -> busy drops the next cycle, no done pulse, pass=0, err_count=1, first_fail=0.
- start re-pulsed mid-sweep -> ignored, sweep length unchanged. Then rst asserted at vec=5 -> all outputs return to 0 asynchronously; a fresh start runs a full clean sweep.
- LU model with a 2-cycle output delay, SETTLE=1 vs SETTLE=2 -> SETTLE=1 reports nonzero err_count; SETTLE=2 reports pass=1.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the OR/NOR logic-unit self-test engine and its bench.
// lu_golden works at the maximum operand width; callers mask down to their own W.
package lu_pkg;

    localparam int LU_MAX_W = 4;

    localparam logic SEL_OR  = 1'b1;
    localparam logic SEL_NOR = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        DONE
    } lu_drv_state_t;

    function automatic logic [LU_MAX_W-1:0] lu_golden(
        input logic [LU_MAX_W-1:0] a,
        input logic [LU_MAX_W-1:0] b,
        input logic                sel
    );
        return (sel == SEL_OR) ? (a | b) : ~(a | b);
    endfunction

endpackage

// File: rtl/lu_settle_timer.sv
// Loadable down-counter that spaces vector drive from result sampling.
// expire is high once the count reaches 1, i.e. after SETTLE enabled cycles from a load.
module lu_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE);

    logic [3:0] count;

    // The count parks at 1 once expired so expire stays stable until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count > 4'd1)) begin
            count <= count - 4'd1;
        end
    end

    assign expire = (count == 4'd1);

endmodule

// File: rtl/lu_vector_driver.sv
// Exhaustive self-test initiator for a W-bit OR/NOR logic unit: sweeps every
// {sel, a, b} vector, compares each result to the golden value and keeps a verdict.
module lu_vector_driver
    import lu_pkg::*;
#(
    parameter int W      = 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     lu_a,
    output logic [W-1:0]     lu_b,
    output logic             lu_sel,
    input  logic [W-1:0]     lu_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W+1:0]   err_count,
    output logic [2*W:0]     first_fail
);

    localparam int N = 2 * W + 1;
    localparam logic [LU_MAX_W-1:0] RESULT_MASK = LU_MAX_W'((1 << W) - 1);

    lu_drv_state_t state, state_next;

    logic [N-1:0]          vec;
    logic                  last_vec;
    logic                  mismatch;
    logic                  timer_load;
    logic                  timer_en;
    logic                  timer_expire;
    logic [LU_MAX_W-1:0]   golden_full;

    assign lu_sel = vec[N-1];
    assign lu_a   = vec[2*W-1:W];
    assign lu_b   = vec[W-1:0];

    assign last_vec    = &vec;
    assign golden_full = lu_golden(LU_MAX_W'(lu_a), LU_MAX_W'(lu_b), lu_sel);
    assign mismatch    = |((golden_full ^ LU_MAX_W'(lu_out)) & RESULT_MASK);

    lu_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WAIT;
            WAIT: begin
                if (abort)             state_next = IDLE;
                else if (timer_expire) state_next = CHECK;
            end
            CHECK: begin
                if (abort)         state_next = IDLE;
                else if (last_vec) state_next = DONE;
                else               state_next = WAIT;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == WAIT) || (state == CHECK);
        done       = (state == DONE);
        timer_en   = (state == WAIT);
        timer_load = ((state == IDLE) && start) ||
                     ((state == CHECK) && !abort && !last_vec);
    end

    // The verdict is settled on the final CHECK so pass is already valid alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                WAIT: begin
                    if (abort) pass <= 1'b0;
                end
                CHECK: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (err_count == '0) first_fail <= vec;
                        end
                        if (last_vec) begin
                            pass <= !mismatch && (err_count == '0);
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_vector_driver.sv
// Randomised self-checking bench: three driver instances (W=1/SETTLE=1, W=2/SETTLE=3,
// W=1/SETTLE=2) each face a configurable logic-unit model; a vector-loop scoreboard predicts verdicts.
module tb_lu_vector_driver;
    import lu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] start_v;
    logic [2:0] abort_v;

    logic       a1, b1, sel1, o1, busy1, done1, pass1;
    logic [3:0] ec1;
    logic [2:0] ff1;
    logic [1:0] a2, b2, o2;
    logic       sel2, busy2, done2, pass2;
    logic [5:0] ec2;
    logic [4:0] ff2;
    logic       a3, b3, sel3, o3, busy3, done3, pass3;
    logic [3:0] ec3;
    logic [2:0] ff3;

    // LU model modes: 0 correct, 1 stuck at 0, 2 sel inverted, 3 random flips, 4 two-cycle delay
    int          mode [3];
    logic [31:0] flip_tab [3];
    logic [3:0]  in_gold [3];
    logic [3:0]  dly1 [3];
    logic [3:0]  dly2 [3];
    logic [3:0]  m_out [3];

    logic busy_v [3];
    logic done_v [3];
    logic pass_v [3];
    int   ec_v [3];
    int   ff_v [3];
    int   vec_v [3];

    int n_checks = 0;
    int n_pass   = 0;

    lu_vector_driver #(.W(1), .SETTLE(1)) u_drv1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .lu_a(a1), .lu_b(b1), .lu_sel(sel1), .lu_out(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .first_fail(ff1)
    );

    lu_vector_driver #(.W(2), .SETTLE(3)) u_drv2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .lu_a(a2), .lu_b(b2), .lu_sel(sel2), .lu_out(o2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2), .first_fail(ff2)
    );

    lu_vector_driver #(.W(1), .SETTLE(2)) u_drv3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
        .lu_a(a3), .lu_b(b3), .lu_sel(sel3), .lu_out(o3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3), .first_fail(ff3)
    );

    function automatic logic [3:0] model_out(input int m, input logic [3:0] a, input logic [3:0] b,
                                             input logic sel, input int v, input logic [31:0] tab,
                                             input logic [3:0] delayed);
        case (m)
            1:       return 4'b0000;
            2:       return lu_golden(a, b, ~sel);
            3:       return lu_golden(a, b, sel) ^ {3'b000, tab[v[4:0]]};
            4:       return delayed;
            default: return lu_golden(a, b, sel);
        endcase
    endfunction

    always_comb begin
        in_gold[0] = lu_golden(4'(a1), 4'(b1), sel1);
        in_gold[1] = lu_golden(4'(a2), 4'(b2), sel2);
        in_gold[2] = lu_golden(4'(a3), 4'(b3), sel3);
        m_out[0] = model_out(mode[0], 4'(a1), 4'(b1), sel1, int'({sel1, a1, b1}), flip_tab[0], dly2[0]);
        m_out[1] = model_out(mode[1], 4'(a2), 4'(b2), sel2, int'({sel2, a2, b2}), flip_tab[1], dly2[1]);
        m_out[2] = model_out(mode[2], 4'(a3), 4'(b3), sel3, int'({sel3, a3, b3}), flip_tab[2], dly2[2]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            dly1[k] <= in_gold[k];
            dly2[k] <= dly1[k];
        end
    end

    assign o1 = m_out[0][0];
    assign o2 = m_out[1][1:0];
    assign o3 = m_out[2][0];

    always_comb begin
        busy_v[0] = busy1;  busy_v[1] = busy2;  busy_v[2] = busy3;
        done_v[0] = done1;  done_v[1] = done2;  done_v[2] = done3;
        pass_v[0] = pass1;  pass_v[1] = pass2;  pass_v[2] = pass3;
        ec_v[0]   = int'(ec1); ec_v[1] = int'(ec2); ec_v[2] = int'(ec3);
        ff_v[0]   = int'(ff1); ff_v[1] = int'(ff2); ff_v[2] = int'(ff3);
        vec_v[0]  = int'({sel1, a1, b1});
        vec_v[1]  = int'({sel2, a2, b2});
        vec_v[2]  = int'({sel3, a3, b3});
    end

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int width_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int nvec_of(input int i);
        return 1 << (2 * width_of(i) + 1);
    endfunction

    // Walks the first nchk vectors in sweep order, judging the LU model against a plain OR/NOR.
    task automatic ref_sweep(input int i, input int nchk, output int ec, output int ff);
        int w    = width_of(i);
        int mask = (1 << w) - 1;
        ec = 0;
        ff = 0;
        for (int v = 0; v < nchk; v++) begin
            logic sel = v[2*w];
            int a = (v >> w) & mask;
            int b = v & mask;
            int act = int'(model_out(mode[i], 4'(a), 4'(b), sel, v, flip_tab[i], 4'b0000)) & mask;
            int exp_val = ((sel == 1'b1) ? (a | b) : ~(a | b)) & mask;
            if (act != exp_val) begin
                if (ec == 0) ff = v;
                ec++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input longint obs, input longint exp_val);
        n_checks++;
        if (obs === exp_val) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_val, $time);
        end
    endtask

    task automatic applyStimulus(input int i, input int repulse_at, input bit chk_order,
                                 output int ec, output int ffo, output logic ps);
        int s       = settle_of(i);
        int exp_lat = nvec_of(i) * (s + 1);
        int c       = 0;
        @(negedge clk);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        checkOutput("busy_after_start", busy_v[i], 1);
        if (chk_order) checkOutput("vec_first", vec_v[i], 0);
        while (!done_v[i] && c < exp_lat + 20) begin
            if (repulse_at > 0 && c == repulse_at) start_v[i] = 1'b1;
            @(posedge clk);
            #1;
            c++;
            start_v[i] = 1'b0;
            if (chk_order && !done_v[i] && (c % (s + 1)) == 0)
                checkOutput("vec_order", vec_v[i], c / (s + 1));
        end
        checkOutput("sweep_latency", done_v[i] ? c : -1, exp_lat);
        ec  = ec_v[i];
        ffo = ff_v[i];
        ps  = pass_v[i];
        checkOutput("busy_at_done", busy_v[i], 0);
        @(posedge clk);
        #1;
        checkOutput("done_single_cycle", done_v[i], 0);
    endtask

    task automatic applyAbort(input int i, input int k);
        int   s = settle_of(i);
        int   c = 0;
        int   e_ec, e_ff;
        logic saw_done = 1'b0;
        @(negedge clk);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        while (c < k * (s + 1)) begin
            @(posedge clk);
            #1;
            c++;
            if (done_v[i]) saw_done = 1'b1;
        end
        checkOutput("abort_vec", vec_v[i], k);
        abort_v[i] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[i] = 1'b0;
        checkOutput("abort_busy_drop", busy_v[i], 0);
        for (int j = 0; j < 3 * nvec_of(i); j++) begin
            if (done_v[i]) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        ref_sweep(i, k, e_ec, e_ff);
        checkOutput("abort_no_done", saw_done, 0);
        checkOutput("abort_pass", pass_v[i], 0);
        checkOutput("abort_vec_hold", vec_v[i], k);
        checkOutput("abort_err_count", ec_v[i], e_ec);
        if (e_ec != 0) checkOutput("abort_first_fail", ff_v[i], e_ff);
    endtask

    task automatic check_sweep(input string tag, input int i, input int ec, input int ffo, input logic ps);
        int e_ec, e_ff;
        ref_sweep(i, nvec_of(i), e_ec, e_ff);
        checkOutput({tag, "_err_count"}, ec, e_ec);
        checkOutput({tag, "_pass"}, ps, (e_ec == 0));
        if (e_ec != 0) checkOutput({tag, "_first_fail"}, ffo, e_ff);
    endtask

    initial begin
        int   ec, ffo, c;
        logic ps;
        rst      = 1'b1;
        start_v  = '0;
        abort_v  = '0;
        for (int k = 0; k < 3; k++) begin
            mode[k]     = 0;
            flip_tab[k] = '0;
        end

        #12;
        checkOutput("reset_busy", busy1 | busy2 | busy3, 0);
        checkOutput("reset_done", done1 | done2 | done3, 0);
        checkOutput("reset_pass", pass1 | pass2 | pass3, 0);
        checkOutput("reset_err_count", ec_v[0] + ec_v[1] + ec_v[2], 0);
        checkOutput("reset_vec", vec_v[0] + vec_v[1] + vec_v[2], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] clean sweep, W=1 SETTLE=1");
        mode[0] = 0;
        applyStimulus(0, 0, 1'b1, ec, ffo, ps);
        check_sweep("clean", 0, ec, ffo, ps);
        checkOutput("clean_pass_const", ps, 1);

        $display("[TB] stuck-at-0 LU, W=1");
        mode[0] = 1;
        applyStimulus(0, 0, 1'b0, ec, ffo, ps);
        check_sweep("stuck0", 0, ec, ffo, ps);
        checkOutput("stuck0_err_const", ec, 4);

        $display("[TB] sel-inverted LU, W=2 SETTLE=3");
        mode[1] = 2;
        applyStimulus(1, 0, 1'b1, ec, ffo, ps);
        check_sweep("selinv", 1, ec, ffo, ps);
        checkOutput("selinv_err_const", ec, 32);

        $display("[TB] abort during WAIT of vec 3");
        mode[0] = 1;
        applyAbort(0, 3);

        $display("[TB] start re-pulsed mid-sweep");
        mode[0] = 0;
        applyStimulus(0, 7, 1'b0, ec, ffo, ps);
        check_sweep("repulse", 0, ec, ffo, ps);

        $display("[TB] reset at vec 5");
        mode[0] = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_vec", vec_v[0], 5);
        #1 rst = 1'b1;
        #1;
        checkOutput("midreset_busy", busy_v[0], 0);
        checkOutput("midreset_err_count", ec_v[0], 0);
        checkOutput("midreset_vec", vec_v[0], 0);
        checkOutput("midreset_done_pass", done_v[0] | pass_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        mode[0] = 0;
        applyStimulus(0, 0, 1'b1, ec, ffo, ps);
        check_sweep("post_reset", 0, ec, ffo, ps);

        $display("[TB] two-cycle-delay LU, SETTLE=1 vs SETTLE=2");
        mode[0] = 4;
        mode[2] = 4;
        applyStimulus(0, 0, 1'b0, ec, ffo, ps);
        checkOutput("delay_s1_has_errors", (ec != 0), 1);
        checkOutput("delay_s1_pass", ps, 0);
        applyStimulus(2, 0, 1'b0, ec, ffo, ps);
        checkOutput("delay_s2_err_count", ec, 0);
        checkOutput("delay_s2_pass", ps, 1);

        $display("[TB] randomised fault tables");
        for (int r = 0; r < 4; r++) begin
            mode[1]     = 3;
            flip_tab[1] = $urandom;
            if (r == 0) flip_tab[1] = '0;
            applyStimulus(1, (r == 1) ? 9 : 0, 1'b0, ec, ffo, ps);
            check_sweep("rand_w2", 1, ec, ffo, ps);
            mode[0]     = 3;
            flip_tab[0] = $urandom;
            applyStimulus(0, 0, 1'b0, ec, ffo, ps);
            check_sweep("rand_w1", 0, ec, ffo, ps);
        end
        mode[0]     = 3;
        flip_tab[0] = $urandom;
        applyAbort(0, int'($urandom_range(1, 7)));
        mode[1]     = 3;
        flip_tab[1] = $urandom;
        applyAbort(1, int'($urandom_range(1, 31)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
